// File: rtl/stage_if.sv
// Instruction fetch stage: assembles a 32-bit little-endian word from four byte reads.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.
module stage_if #(
  parameter int ICACHE_LINES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        br,
  input  logic [5:0]  stall,
  output logic        stall_req,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [1:0]  cnt_r;
  logic [31:0] fetch_pc_r;
  logic [31:0] buf_r;
  logic        last_ack_s;
  logic [31:0] word_s;
  logic        hit_s;
  logic [31:0] hit_data_s;
  logic        unused_s;

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
    $error("stage_if: ICACHE_LINES must be a power of two of at least 2");
  end

  assign last_ack_s = (state_r == FETCH) && mem_ack && (cnt_r == 2'd3);
  assign word_s     = {mem_data, buf_r[23:0]};
  assign unused_s   = ^{stall[5:2], stall[0]};

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]             line_data_r [ICACHE_LINES];
  logic [TAG_W-1:0]        line_tag_r  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] line_valid_r;
  logic [IDX_W-1:0]        lookup_idx_s;
  logic [IDX_W-1:0]        fill_idx_s;
  logic                    fill_s;
  logic                    cache_unused_s;

  assign lookup_idx_s   = pc_i[2 +: IDX_W];
  assign fill_idx_s     = fetch_pc_r[2 +: IDX_W];
  // A fetch aborted by br on its final ack must not fill the line.
  assign fill_s         = last_ack_s && !br;
  assign hit_s          = line_valid_r[lookup_idx_s] &&
                          (line_tag_r[lookup_idx_s] == pc_i[31 -: TAG_W]);
  assign hit_data_s     = line_data_r[lookup_idx_s];
  assign cache_unused_s = ^{pc_i[1:0], fetch_pc_r[1:0]};

  // Line valid bits, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      line_valid_r <= {ICACHE_LINES{1'b0}};
    end else if (fill_s) begin
      line_valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Line data and tag storage.
  always_ff @(posedge clock) begin
    if (fill_s) begin
      line_data_r[fill_idx_s] <= word_s;
      line_tag_r[fill_idx_s]  <= fetch_pc_r[31 -: TAG_W];
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = 32'd0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a branch redirect overrides every other condition.
  always_comb begin
    state_nxt_s = state_r;
    if (br) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = hit_s ? DONE : FETCH;
        FETCH:   state_nxt_s = last_ack_s ? DONE : FETCH;
        DONE:    state_nxt_s = stall[1] ? DONE : IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Byte counter, word assembly and delivered instruction registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r      <= 2'd0;
      fetch_pc_r <= 32'd0;
      buf_r      <= 32'd0;
      if_pc      <= 32'd0;
      if_inst    <= 32'd0;
    end else if (br) begin
      cnt_r <= 2'd0;
      buf_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          fetch_pc_r <= pc_i;
          cnt_r      <= 2'd0;
          if (hit_s) begin
            if_inst <= hit_data_s;
            if_pc   <= pc_i;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            buf_r[{cnt_r, 3'b000} +: 8] <= mem_data;
            cnt_r                       <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              if_inst <= word_s;
              if_pc   <= fetch_pc_r;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = 32'd0;
    if_valid  = 1'b0;
    stall_req = 1'b1;
    case (state_r)
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = fetch_pc_r + {30'd0, cnt_r};
      end
      DONE: begin
        if_valid  = 1'b1;
        stall_req = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed scenarios plus randomized fetches
// checked against a transaction-level memory and cache model.
module tb_stage_if;

  localparam int IW = 6;
`ifdef ICACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_i = 32'd0;
  logic        br = 1'b0;
  logic [5:0]  stall = 6'd0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'd0;
  logic        stall_req;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [logic [31:0]];
  logic [29:0] cmodel [int];

  stage_if #(.ICACHE_LINES(64)) dut (
    .clock(clock), .reset(reset), .pc_i(pc_i), .br(br), .stall(stall),
    .stall_req(stall_req), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rd(input logic [31:0] a);
    logic [31:0] h;
    if (mem.exists(a)) return mem[a];
    h = a * 32'h9E3779B1;
    return h[31:24] ^ a[7:0];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {rd(a + 32'd3), rd(a + 32'd2), rd(a + 32'd1), rd(a)};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[2 +: IW]);
    return CACHE && cmodel.exists(idx) && (cmodel[idx] == a[31:2]);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    cmodel[int'(a[2 +: IW])] = a[31:2];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_valid"}, if_valid, 1'b0);
    chk1({tag, "_stall_req"}, stall_req, 1'b1);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'd0);
  endtask

  task automatic chk_done(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    chk1({tag, "_valid"}, if_valid, 1'b1);
    chk32({tag, "_inst"}, if_inst, exp);
    chk32({tag, "_pc"}, if_pc, pc);
    chk1({tag, "_stall_req"}, stall_req, 1'b0);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'd0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    br      = 1'b0;
    mem_ack = 1'b0;
    step();
    chk32("rst_if_pc", if_pc, 32'd0);
    chk32("rst_if_inst", if_inst, 32'd0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk1("rst_stall_req", stall_req, 1'b1);
    reset = 1'b0;
    cmodel.delete();
  endtask

  // Full fetch from IDLE: wt wait cycles before each ack, hold cycles with
  // stall[1] high in DONE, optionally ended by a branch instead of a release.
  task automatic run_fetch(input logic [31:0] pc, input int wt, input int hold, input bit br_done);
    bit          hit;
    int          lat;
    logic [31:0] exp;
    hit = model_hit(pc);
    exp = word_at(pc);
    lat = 0;
    chk_idle("idle");
    pc_i    = pc;
    br      = 1'b0;
    stall   = 6'd0;
    mem_ack = 1'b0;
    step();
    lat++;
    if (!hit) begin
      for (int k = 0; k < 4; k++) begin
        for (int w = 0; w < wt; w++) begin
          chk1("wait_req", mem_req, 1'b1);
          chk32("wait_addr", mem_addr, pc + k);
          chk1("wait_stall_req", stall_req, 1'b1);
          chk1("wait_valid", if_valid, 1'b0);
          pc_i = $urandom();
          step();
          lat++;
        end
        chk1("fetch_req", mem_req, 1'b1);
        chk32("fetch_addr", mem_addr, pc + k);
        chk1("fetch_stall_req", stall_req, 1'b1);
        chk1("fetch_valid", if_valid, 1'b0);
        mem_ack  = 1'b1;
        mem_data = rd(pc + k);
        pc_i     = $urandom();
        step();
        lat++;
        mem_ack  = 1'b0;
        mem_data = 8'($urandom());
      end
      model_fill(pc);
    end
    chk32("latency", lat, hit ? 32'd1 : 32'(5 + 4 * wt));
    chk_done("done", pc, exp);
    for (int h = 0; h < hold; h++) begin
      stall = 6'($urandom()) | 6'b000010;
      step();
      chk_done("hold", pc, exp);
    end
    if (br_done) begin
      br = 1'b1;
      step();
      chk_idle("br_done");
      br = 1'b0;
    end else begin
      stall = 6'($urandom()) & 6'b111101;
      step();
    end
    stall = 6'd0;
  endtask

  // Fetch aborted by br on byte ab (optionally with that byte's ack), then a
  // late ack while IDLE that must be ignored.
  task automatic run_abort(input logic [31:0] pc, input int ab, input bit with_ack);
    chk_idle("ab_idle");
    pc_i  = pc;
    br    = 1'b0;
    stall = 6'd0;
    step();
    for (int k = 0; k < ab; k++) begin
      chk32("ab_addr", mem_addr, pc + k);
      mem_ack  = 1'b1;
      mem_data = rd(pc + k);
      step();
      mem_ack = 1'b0;
    end
    chk1("ab_req", mem_req, 1'b1);
    chk32("ab_last_addr", mem_addr, pc + ab);
    br       = 1'b1;
    mem_ack  = with_ack;
    mem_data = rd(pc + ab);
    step();
    chk_idle("abort");
    mem_ack  = 1'b1;
    mem_data = 8'hFF;
    step();
    chk_idle("late_ack");
    mem_ack = 1'b0;
    br      = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    mem[32'h0] = 8'h13;
    mem[32'h1] = 8'h05;
    mem[32'h2] = 8'h00;
    mem[32'h3] = 8'h00;

    do_reset();
    run_fetch(32'h0000_0000, 0, 0, 1'b0);
    chk32("first_inst", if_inst, 32'h0000_0513);
    run_fetch(32'h0000_0100, 3, 0, 1'b0);
    run_abort(32'h0000_0300, 1, 1'b1);
    run_fetch(32'h0000_0400, 0, 0, 1'b0);
    run_abort(32'h0000_0040, 3, 1'b1);
    run_fetch(32'h0000_0040, 0, 3, 1'b0);
    run_fetch(32'h0000_1040, 1, 0, 1'b0);
    run_fetch(32'h0000_0040, 0, 0, 1'b0);
    run_fetch(32'h0000_1040, 0, 0, 1'b0);
    run_fetch(32'h0000_1040, 0, 0, 1'b0);
    run_fetch(32'h0000_1040, 0, 1, 1'b1);
`ifndef ICACHE_EN
    run_fetch(32'hFFFF_FFFE, 0, 0, 1'b0);
`endif

    pc_i = 32'h0000_0200;
    step();
    mem_ack  = 1'b1;
    mem_data = rd(32'h0000_0200);
    step();
    mem_ack = 1'b0;
    do_reset();
    run_fetch(32'h0000_0200, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      pc = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 3) == 0)
        run_abort(pc, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else
        run_fetch(pc, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
